// File: rtl/scan_pkg.sv
// scan_pkg: shared state type, Gray sel codes and digit-index mapping helpers
// used by the scan_capture display-frame reconstructor.
package scan_pkg;

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b11;
    localparam logic [1:0] SEL_D3 = 2'b10;

    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        return idx == 2'd0 ? SEL_D0 : idx == 2'd1 ? SEL_D1 : idx == 2'd2 ? SEL_D2 : SEL_D3;
    endfunction

    function automatic logic [3:0] idx_to_digi(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return c + {7'd0, c != 8'hff};
    endfunction

endpackage

// File: rtl/scan_decode.sv
// scan_decode: maps a {sel,digi} sample to its Gray-order digit index and
// flags whether the strobe matches the select.
module scan_decode
    import scan_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [4:1] digi,
    output logic       legal,
    output logic [1:0] idx
);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (sel == idx_to_sel(2'(i))) idx = 2'(i);
        legal = digi == idx_to_digi(idx);
    end

endmodule

// File: rtl/scan_capture.sv
// scan_capture: reassembles four scanned display digits into a full frame,
// detecting out-of-order or malformed strobes.
module scan_capture
    import scan_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               ENA,
    input  logic [1:0]         sel,
    input  logic [4:1]         digi,
    input  logic [SEG_W-1:0]   seg_i,
    output logic [4*SEG_W-1:0] frame_o,
    output logic               frame_valid_o,
    output logic               seq_err_o,
    output logic               locked_o,
    output logic [7:0]         frame_cnt_o,
    output logic [7:0]         err_cnt_o
);

    state_t                    state;
    logic [1:0]                exp_idx;
    logic [2:0][SEG_W-1:0]     shadow;
    logic                      legal;
    logic [1:0]                idx;
    logic                      start;
    logic                      hit;

    scan_decode u_dec (
        .sel   (sel),
        .digi  (digi),
        .legal (legal),
        .idx   (idx)
    );

    assign start    = legal && idx == 2'd0;
    assign hit      = legal && idx == exp_idx;
    assign locked_o = state == LOCKED;

    // Digit 3 goes straight from seg_i into frame_o, so only slots 0..2 are held.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= HUNT;
            exp_idx       <= 2'd0;
            shadow        <= '0;
            frame_o       <= '0;
            frame_valid_o <= 1'b0;
            seq_err_o     <= 1'b0;
            frame_cnt_o   <= 8'd0;
            err_cnt_o     <= 8'd0;
        end else begin
            frame_valid_o <= 1'b0;
            seq_err_o     <= 1'b0;
            if (ENA) begin
                case (state)
                    HUNT: begin
                        if (start) begin
                            shadow  <= {{(2*SEG_W){1'b0}}, seg_i};
                            exp_idx <= 2'd1;
                            state   <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (hit && idx == 2'd3) begin
                            frame_o       <= {seg_i, shadow};
                            frame_valid_o <= 1'b1;
                            frame_cnt_o   <= sat_inc(frame_cnt_o);
                            exp_idx       <= 2'd0;
                        end else if (hit) begin
                            for (int i = 0; i < 3; i++)
                                if (idx == 2'(i)) shadow[i] <= seg_i;
                            exp_idx <= exp_idx + 2'd1;
                        end else begin
                            seq_err_o <= 1'b1;
                            err_cnt_o <= sat_inc(err_cnt_o);
                            shadow    <= start ? {{(2*SEG_W){1'b0}}, seg_i} : '0;
                            exp_idx   <= start ? 2'd1 : 2'd0;
                            state     <= start ? LOCKED : HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: doc/scan_capture.md
SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 Parameter SEG_W, default 8: width of the segment data presented with each digit strobe.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 ENA  input  1  sample enable; sel/digi/seg_i are sampled only in cycles with ENA=1.
REQ-005 sel  input  2  digit select from the display scanner, Gray sequence 00,01,11,10.
REQ-006 digi  input  4 ([4:1])  one-hot digit strobe; legal pairs are 00/0001, 01/0010, 11/0100, 10/1000.
REQ-007 seg_i  input  SEG_W  segment data for the currently strobed digit.
REQ-008 frame_o  output  4*SEG_W  last complete frame; digit0 in [SEG_W-1:0], digit3 in the top SEG_W bits.
REQ-009 frame_valid_o  output  1  one-cycle pulse when frame_o is updated.
REQ-010 seq_err_o  output  1  one-cycle pulse on an illegal or out-of-order sample.
REQ-011 locked_o  output  1  high while in state LOCKED.
REQ-012 frame_cnt_o  output  8  count of completed frames, saturating at 255.
REQ-013 err_cnt_o  output  8  count of seq_err_o pulses, saturating at 255.

Function
REQ-014 A sample is legal when {sel,digi} is one of the four pairs in REQ-006; the digit index is 0..3 in Gray order.
REQ-015 States: HUNT (no partial frame held) and LOCKED (expecting digit index exp_idx).
REQ-016 In HUNT, a legal sample with index 0 stores seg_i in shadow slot 0, sets exp_idx=1, and moves to LOCKED; any other sample is ignored without raising an error.
REQ-017 In LOCKED, a legal sample whose index equals exp_idx stores seg_i in shadow slot exp_idx and advances exp_idx modulo 4.
REQ-018 When the sample for index 3 is accepted, the full shadow frame is copied to frame_o and frame_valid_o pulses in the following cycle (latency 1); the FSM stays LOCKED with exp_idx=0.
REQ-019 In LOCKED, an illegal sample or an index other than exp_idx pulses seq_err_o in the next cycle, discards the partial frame, and returns the FSM to HUNT.
REQ-020 When a mismatching sample is itself a legal index-0 sample, it is accepted as a restart: seq_err_o pulses, slot 0 is stored, exp_idx=1, and the FSM stays LOCKED.
REQ-021 ENA=0 holds all state; there is no timeout, and outputs other than the pulses keep their values.
REQ-022 frame_o changes only on frame completion; a partial or errored frame never reaches frame_o.
REQ-023 frame_cnt_o increments with each frame_valid_o pulse; err_cnt_o increments with each seq_err_o pulse; both counters hold at 255.
REQ-024 frame_valid_o and seq_err_o are never high in the same cycle.

Reset
REQ-025 When rst_ni=0: state HUNT, exp_idx=0, shadow slots=0, frame_o=0, frame_valid_o=0, seq_err_o=0, locked_o=0, frame_cnt_o=0, err_cnt_o=0.
REQ-026 Reset asserted mid-frame discards the partial frame; after release, capture restarts from HUNT.

Structure
REQ-027 Package scan_pkg holds the state enum {HUNT, LOCKED}, the four sel Gray code constants, and the index-to-sel and index-to-digi mapping functions.
REQ-028 Sub-module scan_decode is purely combinational: inputs sel and digi, outputs legal and idx[1:0]; scan_capture instantiates it once.

Verification
REQ-029 After reset, with ENA=1, present 00/0001/A1, 01/0010/B2, 11/0100/C3, 10/1000/D4 on consecutive cycles -> one cycle later frame_o=D4C3B2A1, frame_valid_o=1 for exactly one cycle, frame_cnt_o=1.
REQ-030 While LOCKED with exp_idx=2, present 10/1000 -> seq_err_o pulses, locked_o=0, err_cnt_o=1, and frame_o is unchanged.
REQ-031 Present 01/0100 (illegal pair) while in HUNT -> no error and the FSM stays in HUNT; present the same pair while LOCKED -> seq_err_o pulses.
REQ-032 After digits 0 and 1 are accepted, present 00/0001/55 -> seq_err_o pulses and locked_o stays 1; completing digits 1..3 yields frame_o with slot0=55.
REQ-033 Drop ENA to 0 for 5 cycles between digits 1 and 2 -> no error; the frame completes normally once ENA returns to 1.
REQ-034 Assert rst_ni=0 after digit 2 is accepted -> all outputs 0 immediately; after release, a full frame is captured correctly with frame_cnt_o=1.
